// File: rtl/seven_seg_reader.sv
// Receive side of the hex seven-segment display bus: synchronizes the multiplexed segment and
// select lines, waits for a stable glyph, decodes it and streams per-digit change events.
module seven_seg_reader #(
    parameter int unsigned N_DIGITS      = 4,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned SEG_ACT_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seg_a,
    input  logic                  seg_b,
    input  logic                  seg_c,
    input  logic                  seg_d,
    input  logic                  seg_e,
    input  logic                  seg_f,
    input  logic                  seg_g,
    input  logic [N_DIGITS-1:0]   dig_sel_n,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_digit,
    output logic [3:0]            out_code,
    output logic                  out_blank,
    output logic                  out_err,
    output logic                  overrun,
    output logic [4*N_DIGITS-1:0] disp_codes
);
    localparam int unsigned   CW       = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned   IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES);
    localparam logic [6:0]    SEG_DARK = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     capture;
    logic [6:0]               seg_s1, seg_s2, seg_prev;
    logic [N_DIGITS-1:0]      sel_s1, sel_s2, sel_prev;
    logic [6:0]               lit;
    logic [N_DIGITS-1:0]      sel_act;
    logic [3:0]               sel_hits;
    logic [IW-1:0]            sel_idx;
    logic                     sel_ok;
    logic                     same;
    logic [3:0]               dec_code;
    logic                     dec_blank;
    logic                     dec_err;
    logic [N_DIGITS-1:0][3:0] tbl_code;
    logic [N_DIGITS-1:0]      tbl_blank;
    logic [N_DIGITS-1:0]      tbl_err;
    logic                     changed;
    logic                     evt_pend;
    logic [2:0]               evt_digit;
    logic [3:0]               evt_code;
    logic                     evt_blank;
    logic                     evt_err;

    // Two-flop synchronizers; reset value reads as "all dark, no digit selected".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1   <= SEG_DARK;
            seg_s2   <= SEG_DARK;
            seg_prev <= SEG_DARK;
            sel_s1   <= '1;
            sel_s2   <= '1;
            sel_prev <= '1;
        end else begin
            seg_s1   <= {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a};
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
            sel_s1   <= dig_sel_n;
            sel_s2   <= sel_s1;
            sel_prev <= sel_s2;
        end
    end

    assign lit     = (SEG_ACT_LOW != 0) ? ~seg_s2 : seg_s2;
    assign sel_act = ~sel_s2;
    assign same    = (seg_s2 == seg_prev) && (sel_s2 == sel_prev);
    assign sel_ok  = (sel_hits == 4'd1);

    always_comb begin
        sel_hits = '0;
        sel_idx  = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (sel_act[i]) begin
                sel_hits = sel_hits + 4'd1;
                sel_idx  = IW'(i);
            end
        end
    end

    always_comb begin
        dec_code  = '0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (lit)
            7'h3F: dec_code = 4'h0;
            7'h06: dec_code = 4'h1;
            7'h5B: dec_code = 4'h2;
            7'h4F: dec_code = 4'h3;
            7'h66: dec_code = 4'h4;
            7'h6D: dec_code = 4'h5;
            7'h7D: dec_code = 4'h6;
            7'h07: dec_code = 4'h7;
            7'h7F: dec_code = 4'h8;
            7'h6F: dec_code = 4'h9;
            7'h77: dec_code = 4'hA;
            7'h7C: dec_code = 4'hB;
            7'h39: dec_code = 4'hC;
            7'h5E: dec_code = 4'hD;
            7'h79: dec_code = 4'hE;
            7'h71: dec_code = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Capture fires on the edge where the STABLE_CYCLES-th identical sample is counted.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_ok) begin
                    state_d = ST_SETTLE;
                    count_d = CNT_ONE;
                end else begin
                    count_d = '0;
                end
            end
            ST_SETTLE, ST_HOLD: begin
                if (!same) begin
                    if (sel_ok) begin
                        state_d = ST_SETTLE;
                        count_d = CNT_ONE;
                    end else begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end
                end else if (state_q == ST_SETTLE) begin
                    if (count_q + CNT_ONE == CNT_LAST) begin
                        state_d = ST_HOLD;
                        capture = 1'b1;
                    end
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign changed = (dec_code != tbl_code[sel_idx]) || (dec_blank != tbl_blank[sel_idx]) ||
                     (dec_err != tbl_err[sel_idx]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_code  <= '0;
            tbl_blank <= '1;
            tbl_err   <= '0;
            evt_pend  <= 1'b0;
            evt_digit <= '0;
            evt_code  <= '0;
            evt_blank <= 1'b0;
            evt_err   <= 1'b0;
        end else begin
            evt_pend <= 1'b0;
            if (capture && changed) begin
                tbl_code[sel_idx]  <= dec_code;
                tbl_blank[sel_idx] <= dec_blank;
                tbl_err[sel_idx]   <= dec_err;
                evt_pend           <= 1'b1;
                evt_digit          <= 3'(sel_idx);
                evt_code           <= dec_code;
                evt_blank          <= dec_blank;
                evt_err            <= dec_err;
            end
        end
    end

    assign disp_codes = tbl_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_digit <= '0;
            out_code  <= '0;
            out_blank <= 1'b0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
        end else if (evt_pend) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_digit <= evt_digit;
                out_code  <= evt_code;
                out_blank <= evt_blank;
                out_err   <= evt_err;
            end else begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench for seven_seg_reader: directed vector table, multi-cycle corner cases and
// randomized patterns checked against a glyph-table reference model.
module tb_seven_seg_reader;
    localparam int unsigned ND = 4;
    localparam int unsigned SC = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
    logic [ND-1:0] dig_sel_n;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_digit;
    logic [3:0]    out_code;
    logic          out_blank;
    logic          out_err;
    logic          overrun;
    logic [4*ND-1:0] disp_codes;

    seven_seg_reader #(.N_DIGITS(ND), .STABLE_CYCLES(SC), .SEG_ACT_LOW(1)) dut (
        .clk(clk), .rst(rst),
        .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
        .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g),
        .dig_sel_n(dig_sel_n),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_digit(out_digit), .out_code(out_code),
        .out_blank(out_blank), .out_err(out_err),
        .overrun(overrun), .disp_codes(disp_codes)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [6:0]  lit;
        logic        ev;
        logic [2:0]  digit;
        logic [3:0]  code;
        logic        blank;
        logic        err;
        logic [15:0] disp;
    } vec_t;

    vec_t       vecs [12];
    logic [6:0] glyph [16];
    logic [3:0] scan_vals [4];
    int         vectors = 0;
    int         miscompares = 0;

    int         nvalid, tot_valid, first_at;
    logic [2:0] s_digit;
    logic [3:0] s_code;
    logic       s_blank, s_err;
    logic [3:0] cur_sel;
    logic [6:0] cur_lit;
    bit         rand_mode = 1'b0;

    logic [3:0] m_code  [4];
    logic       m_blank [4];
    logic       m_err   [4];
    logic [8:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns {code, blank, err} from the glyph table.
    function automatic logic [5:0] ref_decode(input logic [6:0] l);
        if (l == 7'h00) return {4'h0, 2'b10};
        for (int k = 0; k < 16; k++) begin
            if (glyph[k] == l) return {4'(k), 2'b00};
        end
        return {4'h0, 2'b01};
    endfunction

    function automatic logic [15:0] model_disp();
        return {m_code[3], m_code[2], m_code[1], m_code[0]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_code[k]  = 4'h0;
            m_blank[k] = 1'b1;
            m_err[k]   = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic model_capture(input logic [3:0] sel, input logic [6:0] l);
        logic [5:0] d;
        int         dig;
        d   = ref_decode(l);
        dig = 0;
        for (int k = 0; k < 4; k++) if (!sel[k]) dig = k;
        if (d != {m_code[dig], m_blank[dig], m_err[dig]}) begin
            m_code[dig]  = d[5:2];
            m_blank[dig] = d[1];
            m_err[dig]   = d[0];
            exp_q.push_back({3'(dig), d});
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [6:0] l);
        logic [6:0] pins;
        pins = ~l;
        {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a} = pins;
        dig_sel_n = sel;
        cur_sel   = sel;
        cur_lit   = l;
    endtask

    task automatic run(input int n);
        logic [8:0] e;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (nvalid == 0) first_at = i;
                nvalid++;
                tot_valid++;
                s_digit = out_digit;
                s_code  = out_code;
                s_blank = out_blank;
                s_err   = out_err;
                if (rand_mode) begin
                    if (exp_q.size() == 0) begin
                        check("rand_event_expected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("rand_event", 32'({out_digit, out_code, out_blank, out_err}), 32'(e));
                    end
                end
            end
        end
    endtask

    task automatic pulse_reset();
        drive(4'hF, 7'h00);
        #2 rst = 1'b1;
        #1;
        check("rst_outputs", 32'({out_valid, out_digit, out_code, out_blank, out_err, overrun}), 32'd0);
        check("rst_disp", 32'(disp_codes), 32'd0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  rsel;
        logic [6:0]  rlit;
        int unsigned h, r;

        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        scan_vals = '{4'h1, 4'hA, 4'h7, 4'hF};
        vecs[0]  = '{4'b1110, 7'h5B, 1'b1, 3'd0, 4'h2, 1'b0, 1'b0, 16'h0002};
        vecs[1]  = '{4'b1101, 7'h77, 1'b1, 3'd1, 4'hA, 1'b0, 1'b0, 16'h00A2};
        vecs[2]  = '{4'b1011, 7'h00, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 16'h00A2};
        vecs[3]  = '{4'b1011, 7'h49, 1'b1, 3'd2, 4'h0, 1'b0, 1'b1, 16'h00A2};
        vecs[4]  = '{4'b0111, 7'h71, 1'b1, 3'd3, 4'hF, 1'b0, 1'b0, 16'hF0A2};
        vecs[5]  = '{4'b1100, 7'h3F, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 16'hF0A2};
        vecs[6]  = '{4'b1111, 7'h7F, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 16'hF0A2};
        vecs[7]  = '{4'b1110, 7'h5B, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 16'hF0A2};
        vecs[8]  = '{4'b1110, 7'h3F, 1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 16'hF0A0};
        vecs[9]  = '{4'b1011, 7'h00, 1'b1, 3'd2, 4'h0, 1'b1, 1'b0, 16'hF0A0};
        vecs[10] = '{4'b1101, 7'h7C, 1'b1, 3'd1, 4'hB, 1'b0, 1'b0, 16'hF0B0};
        vecs[11] = '{4'b0111, 7'h06, 1'b1, 3'd3, 4'h1, 1'b0, 1'b0, 16'h10B0};

        // Power-on reset
        out_ready = 1'b0;
        drive(4'hF, 7'h00);
        rst = 1'b1;
        #1;
        check("por_outputs", 32'({out_valid, out_digit, out_code, out_blank, out_err, overrun}), 32'd0);
        check("por_disp", 32'(disp_codes), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Vector table: each pattern held long enough to capture, consumer always ready
        out_ready = 1'b1;
        for (int v = 0; v < 12; v++) begin
            drive(vecs[v].sel, vecs[v].lit);
            nvalid = 0;
            first_at = -1;
            run(26);
            check($sformatf("vec%0d_events", v), 32'(nvalid), 32'(vecs[v].ev));
            if (vecs[v].ev) begin
                check($sformatf("vec%0d_latency", v), 32'(first_at), 32'(SC + 3));
                check($sformatf("vec%0d_fields", v), 32'({s_digit, s_code, s_blank, s_err}),
                      32'({vecs[v].digit, vecs[v].code, vecs[v].blank, vecs[v].err}));
            end
            check($sformatf("vec%0d_disp", v), 32'(disp_codes), 32'(vecs[v].disp));
        end

        // Backpressure: first event held, second dropped, overrun sticky
        out_ready = 1'b0;
        drive(4'b1110, 7'h6F);
        nvalid = 0;
        first_at = -1;
        run(24);
        check("bp_first_latency", 32'(first_at), 32'(SC + 3));
        check("bp_first_fields", 32'({out_valid, out_digit, out_code, overrun}), 32'({1'b1, 3'd0, 4'h9, 1'b0}));
        drive(4'b1101, 7'h7F);
        run(24);
        check("bp_held_fields", 32'({out_valid, out_digit, out_code, out_blank, out_err}),
              32'({1'b1, 3'd0, 4'h9, 1'b0, 1'b0}));
        check("bp_overrun", 32'(overrun), 32'd1);
        check("bp_disp", 32'(disp_codes), 32'h1089);
        out_ready = 1'b1;
        nvalid = 0;
        run(1);
        check("bp_accept_drop", 32'(out_valid), 32'd0);
        check("bp_overrun_sticky", 32'(overrun), 32'd1);

        // Reset with an event pending and a capture in progress
        out_ready = 1'b0;
        drive(4'b1011, 7'h4F);
        run(22);
        drive(4'b0111, 7'h5B);
        run(8);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        pulse_reset();
        out_ready = 1'b1;
        nvalid = 0;
        run(SC + 6);
        check("post_rst_quiet", 32'(nvalid), 32'd0);

        // Two full scans of 1,A,7,F: only the first scan reports
        tot_valid = 0;
        for (int s = 0; s < 2; s++) begin
            for (int d = 0; d < 4; d++) begin
                drive(4'(~(4'b0001 << d)), glyph[scan_vals[d]]);
                nvalid = 0;
                run(20);
                if (s == 0) begin
                    check($sformatf("scan_d%0d", d), 32'({nvalid[3:0], s_digit, s_code}),
                          32'({4'd1, 3'(d), scan_vals[d]}));
                end
            end
        end
        check("scan_total_events", 32'(tot_valid), 32'd4);
        check("scan_disp", 32'(disp_codes), 32'hF7A1);

        // Two digits selected at once
        drive(4'b1100, 7'h3F);
        nvalid = 0;
        run(50);
        check("multi_sel_events", 32'(nvalid), 32'd0);

        // Pattern toggling faster than the stability window
        nvalid = 0;
        for (int t = 0; t < 8; t++) begin
            drive(4'b1101, (t % 2 == 0) ? 7'h06 : 7'h5B);
            run(8);
        end
        check("glitch_events", 32'(nvalid), 32'd0);

        // Stability boundary: one sample short, then exactly enough
        drive(4'b1110, 7'h7D);
        run(SC - 1);
        drive(4'b1111, 7'h00);
        nvalid = 0;
        run(25);
        check("hold_short_events", 32'(nvalid), 32'd0);
        drive(4'b1110, 7'h7D);
        nvalid = 0;
        run(SC);
        drive(4'b1111, 7'h00);
        run(25);
        check("hold_exact_events", 32'({nvalid[3:0], s_digit, s_code}), 32'({4'd1, 3'd0, 4'h6}));
        check("hold_exact_disp", 32'(disp_codes), 32'hF7A6);

        // Randomized patterns against the reference model
        pulse_reset();
        model_reset();
        rand_mode = 1'b1;
        out_ready = 1'b1;
        nvalid = 0;
        for (int p = 0; p < 80; p++) begin
            do begin
                r = $urandom_range(0, 3);
                if (r != 0) rsel = 4'(~(4'b0001 << $urandom_range(0, 3)));
                else        rsel = 4'($urandom_range(0, 15));
                r = $urandom_range(0, 19);
                if (r < 12)      rlit = glyph[$urandom_range(0, 15)];
                else if (r < 15) rlit = 7'h00;
                else             rlit = 7'($urandom_range(0, 127));
            end while (rsel == cur_sel && rlit == cur_lit);
            h = ($urandom_range(0, 1) != 0) ? $urandom_range(SC, SC + 8) : $urandom_range(1, SC - 1);
            drive(rsel, rlit);
            if (h >= SC && $countones(~rsel) == 1) model_capture(rsel, rlit);
            run(int'(h));
            if (h >= SC + 2) check("rand_disp", 32'(disp_codes), 32'(model_disp()));
        end
        drive(4'b1111, 7'h00);
        run(SC + 8);
        rand_mode = 1'b0;
        check("rand_events_left", 32'(exp_q.size()), 32'd0);
        check("rand_overrun", 32'(overrun), 32'd0);
        check("rand_final_disp", 32'(disp_codes), 32'(model_disp()));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
